// File: rtl/datapath_if.sv
// Control and memory-data bundle for the Mini-SRC datapath: bus drive selects,
// load enables, ALU/MDR mux controls and memory read data.
interface datapath_if;
  logic        PCout, Zlowout, Zhighout, MDRout, R2out, R3out;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
  logic        IncPC, Read, AND;
  logic        R1in, R2in, R3in;
  logic [31:0] Mdatain;

  modport master (
    output PCout, Zlowout, Zhighout, MDRout, R2out, R3out,
    output MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
    output IncPC, Read, AND, R1in, R2in, R3in, Mdatain
  );

  modport slave (
    input PCout, Zlowout, Zhighout, MDRout, R2out, R3out,
    input MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
    input IncPC, Read, AND, R1in, R2in, R3in, Mdatain
  );
endinterface

// File: rtl/datapath.sv
// Mini-SRC single-bus 32-bit datapath: register file subset, PC/IR/MAR/MDR, Y, Z, HI/LO.
// Optional feature macro DATAPATH_MUL_EN: AND=0 selects signed 32x32 multiply instead of add.
module datapath (
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        Zhighout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        LOin,
  input  logic        HIin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        AND,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        Clock,
  input  logic [31:0] Mdatain,
  input  logic        clear
);
  localparam int unsigned W  = 32;
  localparam int unsigned ZW = 2 * W;

  logic [W-1:0]  R1, R2, R3, PC, IR, MAR, MDR, Y, HI, LO;
  logic [ZW-1:0] Z;

  logic [W-1:0]  bus_c;
  logic [ZW-1:0] alu_c;
  logic [W-1:0]  mdr_d;
  logic [W-1:0]  pc_d;

  // Shared bus; fixed-priority source select, zero when idle
  always_comb begin
    bus_c = '0;
    if      (PCout)    bus_c = PC;
    else if (Zlowout)  bus_c = Z[W-1:0];
    else if (Zhighout) bus_c = Z[ZW-1:W];
    else if (MDRout)   bus_c = MDR;
    else if (R2out)    bus_c = R2;
    else if (R3out)    bus_c = R3;
  end

`ifdef DATAPATH_MUL_EN
  logic signed [ZW-1:0] op_a_c, op_b_c;
  always_comb begin
    op_a_c = ZW'($signed(Y));
    op_b_c = ZW'($signed(bus_c));
    alu_c  = AND ? {W'(0), Y & bus_c} : ZW'(op_a_c * op_b_c);
  end
`else
  always_comb begin
    alu_c = AND ? {W'(0), Y & bus_c} : {W'(0), W'(Y + bus_c)};
  end
`endif

  always_comb begin
    mdr_d = Read ? Mdatain : bus_c;
    pc_d  = IncPC ? W'(PC + W'(1)) : bus_c;
  end

  // All loads sample the pre-edge bus, so self-loads see the old value
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      R1  <= '0;
      R2  <= '0;
      R3  <= '0;
      PC  <= '0;
      IR  <= '0;
      MAR <= '0;
      MDR <= '0;
      Y   <= '0;
      HI  <= '0;
      LO  <= '0;
      Z   <= '0;
    end else begin
      if (R1in)  R1  <= bus_c;
      if (R2in)  R2  <= bus_c;
      if (R3in)  R3  <= bus_c;
      if (PCin)  PC  <= pc_d;
      if (IRin)  IR  <= bus_c;
      if (MARin) MAR <= bus_c;
      if (MDRin) MDR <= mdr_d;
      if (Yin)   Y   <= bus_c;
      if (HIin)  HI  <= bus_c;
      if (LOin)  LO  <= bus_c;
      if (Zin)   Z   <= alu_c;
    end
  end
endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath; probes internal registers hierarchically.
module tb_datapath;
  logic Clock;
  logic clear;
  int   errors;
  int   checks;

  datapath_if dif ();

  datapath dut (
    .PCout   (dif.PCout),
    .Zlowout (dif.Zlowout),
    .Zhighout(dif.Zhighout),
    .MDRout  (dif.MDRout),
    .R2out   (dif.R2out),
    .R3out   (dif.R3out),
    .MARin   (dif.MARin),
    .Zin     (dif.Zin),
    .PCin    (dif.PCin),
    .MDRin   (dif.MDRin),
    .IRin    (dif.IRin),
    .Yin     (dif.Yin),
    .LOin    (dif.LOin),
    .HIin    (dif.HIin),
    .IncPC   (dif.IncPC),
    .Read    (dif.Read),
    .AND     (dif.AND),
    .R1in    (dif.R1in),
    .R2in    (dif.R2in),
    .R3in    (dif.R3in),
    .Clock   (Clock),
    .Mdatain (dif.Mdatain),
    .clear   (clear)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dif.PCout = 0; dif.Zlowout = 0; dif.Zhighout = 0; dif.MDRout = 0;
    dif.R2out = 0; dif.R3out = 0; dif.MARin = 0; dif.Zin = 0; dif.PCin = 0;
    dif.MDRin = 0; dif.IRin = 0; dif.Yin = 0; dif.LOin = 0; dif.HIin = 0;
    dif.IncPC = 0; dif.Read = 0; dif.AND = 0; dif.R1in = 0; dif.R2in = 0;
    dif.R3in = 0; dif.Mdatain = '0;
  endtask

  // Apply the currently driven controls for one edge, then release them
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic mem_to_mdr(input logic [31:0] d);
    dif.Read = 1; dif.MDRin = 1; dif.Mdatain = d;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle();
    clear = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_R1", 64'(dut.R1), 64'h0);
    chk("reset_PC", 64'(dut.PC), 64'h0);
    chk("reset_Z",  dut.Z,       64'h0);
    clear = 1'b1;

    // Register loads via memory path
    mem_to_mdr(32'h12); dif.MDRout = 1; dif.R2in = 1; tick();
    mem_to_mdr(32'h14); dif.MDRout = 1; dif.R3in = 1; tick();
    dif.R1in = 1; tick();
    chk("load_R2", 64'(dut.R2), 64'h12);
    chk("load_R3", 64'(dut.R3), 64'h14);
    chk("load_R1_idle_bus", 64'(dut.R1), 64'h0);

    // AND instruction sequence
    dif.PCout = 1; dif.MARin = 1; dif.Zin = 1; tick();
    dif.Zlowout = 1; dif.PCin = 1; dif.IncPC = 1;
    dif.Read = 1; dif.MDRin = 1; dif.Mdatain = 32'h5091_8000; tick();
    dif.MDRout = 1; dif.IRin = 1; tick();
    dif.R2out = 1; dif.Yin = 1; tick();
    dif.R3out = 1; dif.AND = 1; dif.Zin = 1; tick();
    chk("and_Z", dut.Z, 64'h10);
    dif.Zlowout = 1; dif.R1in = 1; tick();
    chk("and_IR",  64'(dut.IR),  64'h5091_8000);
    chk("and_PC",  64'(dut.PC),  64'h1);
    chk("and_MAR", 64'(dut.MAR), 64'h0);
    chk("and_R1",  64'(dut.R1),  64'h10);

    // Asynchronous reset between edges
    #2;
    clear = 1'b0;
    #1;
    chk("areset_R1", 64'(dut.R1), 64'h0);
    chk("areset_IR", 64'(dut.IR), 64'h0);
    chk("areset_Z",  dut.Z,       64'h0);
    #1;
    clear = 1'b1;
    @(negedge Clock);

    // Alternate ALU op: Y=0x12, bus=0x14
    mem_to_mdr(32'h12); dif.MDRout = 1; dif.Yin = 1; tick();
    mem_to_mdr(32'h14); dif.MDRout = 1; dif.R3in = 1; tick();
    dif.R3out = 1; dif.Zin = 1; tick();
`ifdef DATAPATH_MUL_EN
    chk("mul_Z", dut.Z, 64'h168);
`else
    chk("add_Z", dut.Z, 64'h26);
`endif
    dif.Zhighout = 1; dif.HIin = 1; tick();
    dif.Zlowout = 1; dif.LOin = 1; tick();
    chk("op_HI", 64'(dut.HI), 64'h0);
`ifdef DATAPATH_MUL_EN
    chk("op_LO", 64'(dut.LO), 64'h168);
`else
    chk("op_LO", 64'(dut.LO), 64'h26);
`endif

    // Negative operand: Y=0xFFFFFFFE, bus=3
    mem_to_mdr(32'hFFFF_FFFE); dif.MDRout = 1; dif.Yin = 1; tick();
    mem_to_mdr(32'h3); dif.MDRout = 1; dif.Zin = 1; tick();
`ifdef DATAPATH_MUL_EN
    chk("neg_Zhi", 64'(dut.Z[63:32]), 64'hFFFF_FFFF);
    chk("neg_Zlo", 64'(dut.Z[31:0]),  64'hFFFF_FFFA);
`else
    chk("neg_Z", dut.Z, 64'h1);
`endif

    // Zlowout outranks Zhighout
    dif.Zlowout = 1; dif.Zhighout = 1; dif.R1in = 1; tick();
`ifdef DATAPATH_MUL_EN
    chk("prio_zlo", 64'(dut.R1), 64'hFFFF_FFFA);
`else
    chk("prio_zlo", 64'(dut.R1), 64'h1);
`endif

    // PC increment wraps, ignoring a driven bus
    mem_to_mdr(32'hFFFF_FFFF); dif.MDRout = 1; dif.PCin = 1; tick();
    chk("pc_load", 64'(dut.PC), 64'hFFFF_FFFF);
    dif.MDRout = 1; dif.PCin = 1; dif.IncPC = 1; tick();
    chk("pc_wrap", 64'(dut.PC), 64'h0);

    // Bus priority PCout over MDRout
    mem_to_mdr(32'h5); dif.MDRout = 1; dif.PCin = 1; tick();
    mem_to_mdr(32'h9);
    dif.PCout = 1; dif.MDRout = 1; dif.R2in = 1; tick();
    chk("prio_pc", 64'(dut.R2), 64'h5);

    // Self-load sees old value; multiple loads share one bus value
    dif.MDRout = 1; dif.Read = 1; dif.MDRin = 1; dif.Mdatain = 32'hA5;
    dif.R3in = 1; dif.Yin = 1; tick();
    chk("old_mdr_R3", 64'(dut.R3),  64'h9);
    chk("old_mdr_Y",  64'(dut.Y),   64'h9);
    chk("new_mdr",    64'(dut.MDR), 64'hA5);

    // Reset wins over an enable at the same edge
    @(negedge Clock);
    clear = 1'b0;
    dif.PCin = 1; dif.IncPC = 1;
    tick();
    chk("reset_wins_PC", 64'(dut.PC), 64'h0);
    clear = 1'b1;
    @(negedge Clock);
    dif.PCin = 1; dif.IncPC = 1; tick();
    chk("resume_PC", 64'(dut.PC), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
